// File: rtl/add_pkg.sv
// Shared definitions for the adder arbiter and any later block that
// time-shares a datapath among several requesters.
//   DATA_W       : operand / result width of the shared adder
//   MAX_REQ      : largest requester count the round-robin helper supports
//   slot_state_e : occupancy of a single registered response slot
//   rr_pick()    : round-robin grant index search
package add_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_REQ  = 16;
  localparam int unsigned MAX_ID_W = 4;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Returns the first set index of valid[num_req-1:0], searching upward from
  // ptr and wrapping. Iterates from the farthest candidate down so the nearest
  // one is written last and wins. Returns 0 when nothing is valid; callers
  // qualify the result with |valid.
  function automatic logic [MAX_ID_W-1:0] rr_pick(input logic [MAX_REQ-1:0]  valid,
                                                   input logic [MAX_ID_W-1:0] ptr,
                                                   input int unsigned         num_req);
    logic [MAX_ID_W-1:0] pick;
    logic [MAX_ID_W:0]   idx;
    pick = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < int'(num_req)) begin
        // ptr < num_req and k < num_req, so one subtraction is a full modulo.
        idx = {1'b0, ptr} + (MAX_ID_W + 1)'(k);
        if (idx >= (MAX_ID_W + 1)'(num_req)) begin
          idx = idx - (MAX_ID_W + 1)'(num_req);
        end
        if (valid[idx[MAX_ID_W-1:0]]) begin
          pick = idx[MAX_ID_W-1:0];
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/Add.sv
// Shared combinational adder datapath. Carry-out is discarded, so the sum
// wraps modulo 2^DATA_W.
//   a, b : operands
//   sum  : (a + b) mod 2^DATA_W
module Add
  import add_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first valid requester at or
// above the priority pointer, wrapping around.
//   valid     : request vector
//   ptr       : index with highest priority this cycle
//   any_valid : at least one request is present
//   grant_idx : index of the winner (0 when any_valid=0)
//   grant     : one-hot grant, all-zero when any_valid=0
module rr_arbiter
  import add_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic               any_valid,
  output logic [ID_W-1:0]    grant_idx,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    any_valid = |valid;
    grant_idx = ID_W'(rr_pick(MAX_REQ'(valid), MAX_ID_W'(ptr), NUM_REQ));
    grant     = '0;
    if (any_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// Time-shares one 32-bit adder among NUM_REQ requesters. A round-robin
// arbiter accepts at most one request per cycle; the wrapped sum and the
// requester index land in a single registered response slot one cycle later.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_valid  : per-requester request valid
//   req_ready  : per-requester accept (at most one bit set)
//   req_a/b    : packed operands, requester i in bits [32*i+31:32*i]
//   rsp_valid  : response slot holds a result
//   rsp_ready  : consumer accepts the response
//   rsp_id     : requester that produced rsp_sum
//   rsp_sum    : (a + b) mod 2^32
//   op_count   : responses consumed since reset, wrapping
module add_arbiter
  import add_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ),
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_sum,
  output logic [CNT_W-1:0]          op_count
);

  slot_state_e         state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     rsp_id_q;
  logic [DATA_W-1:0]   rsp_sum_q;
  logic [CNT_W-1:0]    op_count_q;

  logic                any_valid;
  logic [ID_W-1:0]     grant_idx;
  logic [NUM_REQ-1:0]  grant;
  logic                can_accept;
  logic                accept;
  logic                consume;

  logic [DATA_W-1:0]   op_a [NUM_REQ];
  logic [DATA_W-1:0]   op_b [NUM_REQ];
  logic [DATA_W-1:0]   add_a, add_b, add_sum;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op_a[i] = req_a[DATA_W*i +: DATA_W];
    assign op_b[i] = req_b[DATA_W*i +: DATA_W];
  end

  // Grant depends only on req_valid and the pointer, never on req_ready.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .valid     (req_valid),
    .ptr       (rr_ptr_q),
    .any_valid (any_valid),
    .grant_idx (grant_idx),
    .grant     (grant)
  );

  assign add_a = op_a[grant_idx];
  assign add_b = op_b[grant_idx];

  Add u_add (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  always_comb begin
    // A full slot being drained this cycle can be refilled in the same cycle.
    can_accept = (state_q == SLOT_EMPTY) || rsp_ready;
    // rst_n gates the handshake so no requester sees an accept during reset.
    accept     = rst_n && any_valid && can_accept;
    req_ready  = accept ? grant : '0;
    consume    = (state_q == SLOT_FULL) && rsp_ready;

    state_d = state_q;
    unique case (state_q)
      SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
      SLOT_FULL:  if (rsp_ready && !accept) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase

    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SLOT_EMPTY;
      rr_ptr_q   <= '0;
      rsp_id_q   <= '0;
      rsp_sum_q  <= '0;
      op_count_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (accept) begin
        rsp_id_q  <= grant_idx;
        rsp_sum_q <= add_sum;
      end
      if (consume) begin
        op_count_q <= op_count_q + CNT_W'(1);
      end
    end
  end

  assign rsp_valid = (state_q == SLOT_FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign op_count  = op_count_q;

endmodule
